// File: rtl/serializador_paridade_if.sv
// Handshake and serial-output bundle between the word source, the serializer and the parity detector.
// Signals: data_in/data_valid come from upstream and data_ready goes back to it.
// clr_out/bit_out/bit_valid/frame_start/frame_end/busy go downstream to the detector.
interface serializador_paridade_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             clr_out;
  logic             bit_out;
  logic             bit_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  // Upstream word source plus the observer of the serial side.
  modport master (
    output data_in, data_valid,
    input  data_ready, clr_out, bit_out, bit_valid, frame_start, frame_end, busy
  );

  // The serializer itself.
  modport slave (
    input  data_in, data_valid,
    output data_ready, clr_out, bit_out, bit_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/serializador_paridade.sv
// Parallel-to-serial stage feeding the serial parity detector. clr_out pulses once before every frame.
// Latency: clr_out 1 cycle after the handshake, first bit at +2, last bit at +1+WIDTH (+1 with parity).
// Backpressure: data_ready is high only in IDLE. Upstream holds data_in/data_valid until they are accepted.
// Ports: clk, reset (synchronous, active-high), bus (serializador_paridade_if.slave).
// Optional macro PARITY_APPEND_EN appends an even-parity bit that carries frame_end.
module serializador_paridade #(
  parameter int WIDTH     = 8,   // 2..32
  parameter int LSB_FIRST = 1,
  parameter int GAP       = 0    // 0..15
) (
  input  logic                 clk,
  input  logic                 reset,
  serializador_paridade_if.slave bus
);

  localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

`ifdef PARITY_APPEND_EN
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, PAR, GAP_S} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, GAP_S} state_t;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             handshake;
  logic             last_bit;
`ifdef PARITY_APPEND_EN
  logic             par_q;   // even parity of the accepted word, captured before shifting destroys it
`endif

  assign handshake = bus.data_valid && (state == IDLE);
  assign last_bit  = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      gcnt  <= '0;
`ifdef PARITY_APPEND_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (handshake) begin
            sreg <= bus.data_in;
`ifdef PARITY_APPEND_EN
            par_q <= ^bus.data_in;
`endif
          end
        end
        SHIFT: begin
          if (LSB_FIRST != 0) sreg <= sreg >> 1;
          else                sreg <= sreg << 1;
          cnt <= last_bit ? '0 : cnt + CW'(1);
        end
        GAP_S: begin
          gcnt <= (gcnt == GAP_LAST) ? 4'd0 : gcnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx         = state;
    bus.data_ready   = 1'b0;
    bus.busy         = 1'b0;
    bus.clr_out      = 1'b0;
    bus.bit_out      = 1'b0;
    bus.bit_valid    = 1'b0;
    bus.frame_start  = 1'b0;
    bus.frame_end    = 1'b0;
    case (state)
      IDLE: begin
        bus.data_ready = 1'b1;
        if (handshake) state_nx = CLR;
      end
      CLR: begin
        bus.busy    = 1'b1;
        bus.clr_out = 1'b1;
        state_nx    = SHIFT;
      end
      SHIFT: begin
        bus.busy        = 1'b1;
        bus.bit_valid   = 1'b1;
        bus.bit_out     = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
        bus.frame_start = (cnt == '0);
`ifdef PARITY_APPEND_EN
        if (last_bit) state_nx = PAR;
`else
        // Without a parity bit the last data bit closes the frame.
        bus.frame_end = last_bit;
        if (last_bit) state_nx = (GAP > 0) ? GAP_S : IDLE;
`endif
      end
`ifdef PARITY_APPEND_EN
      PAR: begin
        bus.busy      = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_out   = par_q;
        bus.frame_end = 1'b1;
        state_nx      = (GAP > 0) ? GAP_S : IDLE;
      end
`endif
      GAP_S: begin
        bus.busy = 1'b1;
        if (gcnt == GAP_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serializador_paridade.sv
module tb_serializador_paridade;

`ifdef PARITY_APPEND_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serializador_paridade_if #(.WIDTH(8)) b ();
  serializador_paridade_if #(.WIDTH(8)) b6 ();

  serializador_paridade #(.WIDTH(8), .LSB_FIRST(1), .GAP(0)) dut (
    .clk(clk), .reset(reset), .bus(b)
  );
  serializador_paridade #(.WIDTH(8), .LSB_FIRST(0), .GAP(2)) dut6 (
    .clk(clk), .reset(reset), .bus(b6)
  );

  // Behavioural parity detector: restarts on clr_out, toggles on every 1 bit.
  logic det;
  always @(posedge clk) begin
    if (reset || b.clr_out) det <= 1'b0;
    else if (b.bit_out)     det <= ~det;
  end

  // Counts clr_out pulses of the main DUT.
  int clr_cnt = 0;
  always @(posedge clk) if (b.clr_out) clr_cnt <= clr_cnt + 1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {b.data_ready, b.busy, b.clr_out, b.bit_out, b.bit_valid, b.frame_start, b.frame_end};
  endfunction

  logic [7:0] w;
  logic [7:0] w2;
  int         c0;
  logic       seen_fe, seen_bv;

  initial begin
    reset = 1'b1;
    b.data_in = '0;  b.data_valid = 1'b0;
    b6.data_in = '0; b6.data_valid = 1'b0;

    // 1: reset state and idle outputs
    step(); step();
    check("t1_reset_outs", 32'(outs()), 32'h40);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_idle_outs", 32'(outs()), 32'h40);
    end

    // 2: 8'hA5, LSB first
    w = 8'hA5;
    b.data_in = w; b.data_valid = 1'b1;
    step();
    b.data_valid = 1'b0;
    check("t2_clr", 32'(b.clr_out), 1);
    check("t2_bv_in_clr", 32'(b.bit_valid), 0);
    check("t2_ready_low", 32'(b.data_ready), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t2_bit", 32'(b.bit_out), 32'(w[i]));
      check("t2_bv", 32'(b.bit_valid), 1);
      check("t2_fs", 32'(b.frame_start), 32'(i == 0));
      check("t2_fe", 32'(b.frame_end), 32'((i == 7) && (PB == 0)));
    end
`ifdef PARITY_APPEND_EN
    step();
    check("t2_par_bit", 32'(b.bit_out), 32'(^w));
    check("t2_par_fe", 32'(b.frame_end), 1);
`endif
    step();
    check("t2_ready_back", 32'(b.data_ready), 1);
    check("t2_busy_low", 32'(b.busy), 0);
    check("t2_det", 32'(det), 0);

`ifdef PARITY_APPEND_EN
    // 3: 8'h07, parity bit appended
    w = 8'h07;
    b.data_in = w; b.data_valid = 1'b1;
    step();
    b.data_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t3_bit", 32'(b.bit_out), 32'(w[i]));
      check("t3_fe_data", 32'(b.frame_end), 0);
    end
    step();
    check("t3_par_bit", 32'(b.bit_out), 1);
    check("t3_par_fe", 32'(b.frame_end), 1);
    check("t3_par_bv", 32'(b.bit_valid), 1);
    step();
    check("t3_det", 32'(det), 0);
    check("t3_ready", 32'(b.data_ready), 1);
`endif

    // 4: back-to-back words with data_valid held high
    c0 = clr_cnt;
    w  = 8'h01;
    w2 = 8'h80;
    b.data_in = w; b.data_valid = 1'b1;
    step();
    b.data_in = w2;
    check("t4_clr1", 32'(b.clr_out), 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_bits1", 32'(b.bit_out), 32'(w[i]));
      check("t4_noclr1", 32'(b.clr_out), 0);
    end
    for (int i = 0; i < PB; i++) step();
    step();
    check("t4_ready_gap", 32'(b.data_ready), 1);
    step();
    b.data_valid = 1'b0;
    check("t4_clr2", 32'(b.clr_out), 1);
    check("t4_no_overlap", 32'(b.bit_valid), 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t4_bits2", 32'(b.bit_out), 32'(w2[i]));
    end
    for (int i = 0; i < PB + 2; i++) step();
    check("t4_clr_count", 32'(clr_cnt - c0), 2);
    check("t4_idle", 32'(b.data_ready), 1);

    // 5: reset on the 4th bit of 8'hFF aborts the frame
    b.data_in = 8'hFF; b.data_valid = 1'b1;
    step();
    b.data_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t5_4th_bit", 32'(b.bit_valid & b.bit_out), 1);
    reset = 1'b1;
    step();
    check("t5_ready", 32'(b.data_ready), 1);
    check("t5_bv", 32'(b.bit_valid), 0);
    check("t5_busy", 32'(b.busy), 0);
    reset = 1'b0;
    seen_fe = 1'b0;
    seen_bv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen_fe |= b.frame_end;
      seen_bv |= b.bit_valid;
    end
    check("t5_no_fe", 32'(seen_fe), 0);
    check("t5_no_bv", 32'(seen_bv), 0);

    // 6: MSB first with GAP=2, 8'hC0
    w = 8'hC0;
    b6.data_in = w; b6.data_valid = 1'b1;
    step();
    b6.data_valid = 1'b0;
    check("t6_clr", 32'(b6.clr_out), 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t6_bit", 32'(b6.bit_out), 32'(w[7-i]));
      check("t6_fe", 32'(b6.frame_end), 32'((i == 7) && (PB == 0)));
    end
    for (int i = 0; i < PB; i++) step();
    step();
    check("t6_gap1_ready", 32'(b6.data_ready), 0);
    check("t6_gap1_bv", 32'(b6.bit_valid | b6.bit_out), 0);
    step();
    check("t6_gap2_ready", 32'(b6.data_ready), 0);
    step();
    check("t6_ready_back", 32'(b6.data_ready), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
